// File: rtl/md_scheduler.sv
// Multi-cycle HI/LO multiply/divide sequencer for the E stage.
// Holds the unit busy for a fixed latency, then commits HI/LO.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(NMAX + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;
  logic          done_q;

  logic op_mult, op_multu, op_div, op_divu;
  logic op_mthi, op_mtlo, op_md, op_mul;

  assign op_mult  = (op == 4'd1);
  assign op_multu = (op == 4'd2);
  assign op_div   = (op == 4'd3);
  assign op_divu  = (op == 4'd4);
  assign op_mthi  = (op == 4'd5);
  assign op_mtlo  = (op == 4'd6);
  assign op_mul   = op_mult | op_multu;
  assign op_md    = op_mul | op_div | op_divu;

  logic accept;
  assign accept = start & ~flush & (state == IDLE);

  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so INT_MIN / -1 needs no special path
  logic [31:0] a_mag, b_mag, dvd, dvs, dvs_nz;
  logic [31:0] quo, rem;
  assign a_mag  = a[31] ? (~a + 32'd1) : a;
  assign b_mag  = b[31] ? (~b + 32'd1) : b;
  assign dvd    = op_div ? a_mag : a;
  assign dvs    = op_div ? b_mag : b;
  assign dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;
  assign quo    = dvd / dvs_nz;
  assign rem    = dvd % dvs_nz;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    unique case (1'b1)
      op_mult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      op_multu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      op_div: begin
        res_lo = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
        res_hi = a[31] ? (~rem + 32'd1) : rem;
        res_wr = (b != 32'd0);
      end
      op_divu: begin
        res_lo = quo;
        res_hi = rem;
        res_wr = (b != 32'd0);
      end
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_md) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= res_wr;
              cnt     <= op_mul ? CW'(MULT_CYCLES)
                                : CW'(DIV_CYCLES);
              state   <= RUN;
            end else if (op_mthi) begin
              hi_q <= a;
            end else if (op_mtlo) begin
              lo_q <= a;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == RUN);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = d_is_md & (busy | (start & op_md));

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler.
// Hand-computed HI/LO results and busy/stall/done timing.
module tb_md_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  md_scheduler #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall_md(stall_md),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && start && busy) begin
      assert (1'b0) else begin
        n_bad++;
        $error("FAIL start_in_run: start seen while busy");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic md_op(input logic [3:0]  o,
                       input logic [31:0] av,
                       input logic [31:0] bv,
                       input int          n,
                       input logic [31:0] pre_hi,
                       input logic [31:0] pre_lo,
                       input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo,
                       input int          flush_cyc,
                       input logic        dmd);
    int c;
    start   = 1'b1;
    op      = o;
    a       = av;
    b       = bv;
    d_is_md = dmd;
    #1;
    chk("stall_issue", {31'd0, stall_md}, {31'd0, dmd});
    tick();
    start = 1'b0;
    op    = 4'd0;
    c     = 0;
    while (busy && c < 40) begin
      c++;
      chk("stall_run", {31'd0, stall_md}, {31'd0, dmd});
      chk("hold_hi", hi, pre_hi);
      chk("hold_lo", lo, pre_lo);
      chk("no_early_done", {31'd0, done}, 32'd0);
      flush = (c == flush_cyc);
      tick();
    end
    flush = 1'b0;
    chk("busy_len", 32'(c), 32'(n));
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("res_hi", hi, exp_hi);
    chk("res_lo", lo, exp_lo);
    chk("stall_after", {31'd0, stall_md}, 32'd0);
    tick();
    chk("done_off", {31'd0, done}, 32'd0);
    d_is_md = 1'b0;
  endtask

  task automatic mt(input logic [3:0]  o,
                    input logic [31:0] av,
                    input logic        fl,
                    input logic [31:0] exp_hi,
                    input logic [31:0] exp_lo);
    start = 1'b1;
    op    = o;
    a     = av;
    flush = fl;
    tick();
    start = 1'b0;
    op    = 4'd0;
    flush = 1'b0;
    chk("mt_busy", {31'd0, busy}, 32'd0);
    chk("mt_hi", hi, exp_hi);
    chk("mt_lo", lo, exp_lo);
  endtask

  initial begin
    int   k;
    logic seen;
    reset   = 1'b0;
    start   = 1'b0;
    op      = 4'd0;
    a       = 32'd0;
    b       = 32'd0;
    flush   = 1'b0;
    d_is_md = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall_md}, 32'd0);
    reset = 1'b1;
    tick();

    md_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5,
          32'h0, 32'h0,
          32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 1'b1);

    md_op(4'd2, 32'hFFFF_FFFE, 32'd3, 5,
          32'hFFFF_FFFF, 32'hFFFF_FFFA,
          32'h0000_0002, 32'hFFFF_FFFA, 2, 1'b0);

    md_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10,
          32'h0000_0002, 32'hFFFF_FFFA,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b1);

    mt(4'd5, 32'h1234, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    mt(4'd5, 32'h1234, 1'b0, 32'h0000_1234, 32'hFFFF_FFFD);
    mt(4'd5, 32'h11, 1'b0, 32'h11, 32'hFFFF_FFFD);
    mt(4'd6, 32'h22, 1'b0, 32'h11, 32'h22);

    md_op(4'd4, 32'd7, 32'd0, 10,
          32'h11, 32'h22, 32'h11, 32'h22, 0, 1'b0);

    md_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
          32'h11, 32'h22,
          32'h0, 32'h8000_0000, 0, 1'b0);

    start = 1'b1;
    op    = 4'd1;
    a     = 32'd9;
    b     = 32'd9;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    op    = 4'd0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    chk("flush_start_lo", lo, 32'h8000_0000);

    mt(4'd5, 32'h55, 1'b0, 32'h55, 32'h8000_0000);
    start = 1'b1;
    op    = 4'd1;
    a     = 32'd3;
    b     = 32'd5;
    tick();
    start = 1'b0;
    op    = 4'd0;
    tick();
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    seen  = 1'b0;
    for (k = 0; k < 8; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("arst_no_commit", {31'd0, seen}, 32'd0);
    chk("arst_lo_after", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Sequences the multi-cycle multiply/divide resource used by the E stage.
- Accepts one HI/LO operation per start pulse, holds the unit busy for a fixed latency, then commits HI/LO.
- Drives the busy and stall signals that hazard control uses to hold MD-class instructions in D.
- Honours exception/interrupt flush so that a victim instruction never alters HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥2)
- DIV_CYCLES, 10, busy cycles for div/divu (≥2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is an MD-class op (one-cycle qualifier)
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; others treated as none
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- flush  input  1  exception/eret redirect this cycle; E-stage instruction is cancelled
- d_is_md  input  1  D-stage instruction reads or writes HI/LO
- busy  output  1  computation in progress
- stall_md  output  1  d_is_md & (busy | start & op in 1..4)
- done  output  1  one-cycle pulse in the cycle HI/LO commit becomes visible
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, reset=0): state IDLE; counter=0; busy=0; done=0; hi=0; lo=0; pending result=0. All outputs return to these values immediately, including mid-computation; the in-flight result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, flush=0, op 1..4:
  - latch the full result into pending_hi/pending_lo at the edge;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, start=1, flush=0, op 5/6: write a to hi (5) or lo (6) at the edge; stay IDLE; busy stays 0.
- start with flush=1: ignored entirely. No state change, no HI/LO write.
- RUN:
  - counter decrements each edge; busy=1 throughout RUN;
  - busy is high for exactly N cycles starting the cycle after the start edge;
  - on the edge where counter reaches 1: hi/lo ← pending, state → IDLE, done=1 for the following cycle.
- flush during RUN does not abort. The operation belongs to an older, committed instruction and completes normally.
- start while RUN: ignored. It is a protocol violation that stall_md prevents; the bench asserts that it never occurs under legal stimulus.
- Back-to-back: a new start may be accepted in the cycle after the commit edge (busy=0).
- Arithmetic:
  - mult: signed 32×32→64, {hi,lo}=product.
  - multu: the same, unsigned.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide special cases:
  - divide by zero (b=0): hi/lo keep their prior values at commit, busy duration unchanged, done still pulses.
  - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
- hi/lo are readable combinationally at all times (mfhi/mflo are served in E); during RUN they show the pre-operation values.
- stall_md is purely combinational from the listed inputs and state.

Test Plan:
- Reset low mid-RUN (cycle 3 of a mult) → busy=0, hi=lo=0 immediately; after release, no commit and no done pulse occur.
- start, op=1, a=0xFFFFFFFE, b=3 → busy high 5 cycles; done pulses next; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat with op=2 → hi=0x00000002, lo=0xFFFFFFFA.
- start, op=3, a=-7 (0xFFFFFFF9), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. op=4, a=7, b=0 with prior hi=0x11, lo=0x22 → hi/lo unchanged after 10 busy cycles.
- start, op=3, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- start, op=5, a=0x1234, flush=1 → hi unchanged, busy=0. Same with flush=0 → hi=0x1234 next cycle, no busy.
- mult in RUN with d_is_md=1 → stall_md=1 every busy cycle, 0 the cycle after commit. Assert flush in RUN cycle 2 → commit still happens on schedule. With d_is_md=1 and start, op=1 in IDLE → stall_md=1 in that same cycle.
